// File: rtl/matrix_operand_loader_if.sv
// matrix_operand_loader_if
//   Byte-stream handshake into the operand loader.
//   in_valid : upstream element valid
//   in_data  : operand element
//   in_last  : final element of a frame
//   in_ready : loader can accept an element
//   master modport = upstream source, slave modport = loader.
interface matrix_operand_loader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  in_ready;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Unpacks a row-major byte stream (N*N elements of A, then N*N of B) into
//   the operand registers, pulses start_mult, then holds the operands frozen
//   until mult_done or the watchdog expires. Misplaced/missing in_last flags
//   frame_err and resynchronises to the next frame.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   in_if           : stream handshake (slave side)
//   a_flat, b_flat  : operands, element (i,j) at [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]
//   start_mult      : one-cycle start pulse to the host
//   mult_done       : completion pulse from the host
//   busy            : high while starting/waiting on the host
//   frame_err       : one-cycle pulse on a framing error
//   timeout         : one-cycle pulse on watchdog expiry
//   frame_count     : frames completed by mult_done (wrapping)
module matrix_operand_loader #(
   parameter int MATRIX_SIZE    = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                          clk,
   input  logic                                          rst,
   matrix_operand_loader_if.slave                        in_if,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] a_flat,
   output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] b_flat,
   output logic                                          start_mult,
   input  logic                                          mult_done,
   output logic                                          busy,
   output logic                                          frame_err,
   output logic                                          timeout,
   output logic [15:0]                                   frame_count
);
   localparam int NN    = MATRIX_SIZE * MATRIX_SIZE;
   localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] LOAD_A    = 2'd0;
   localparam logic [1:0] LOAD_B    = 2'd1;
   localparam logic [1:0] START     = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [WD_W-1:0]  wd;
   logic             xfer;

   assign in_if.in_ready = rst && ((state == LOAD_A) || (state == LOAD_B));
   assign xfer           = in_if.in_valid && in_if.in_ready;
   assign start_mult     = (state == START);
   assign busy           = (state == START) || (state == WAIT_DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= LOAD_A;
         idx         <= '0;
         wd          <= '0;
         a_flat      <= '0;
         b_flat      <= '0;
         frame_count <= '0;
         frame_err   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         timeout   <= 1'b0;
         case (state)
            LOAD_A: begin
               if (xfer) begin
                  if (in_if.in_last) begin
                     // early in_last: drop the element and restart the frame
                     frame_err <= 1'b1;
                     idx       <= '0;
                  end else begin
                     a_flat[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_if.in_data;
                     if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= LOAD_B;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  if (idx == IDX_LAST) begin
                     // final element is kept; only a missing in_last aborts the start
                     b_flat[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_if.in_data;
                     idx <= '0;
                     if (in_if.in_last) begin
                        state <= START;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= LOAD_A;
                     end
                  end else if (in_if.in_last) begin
                     frame_err <= 1'b1;
                     idx       <= '0;
                     state     <= LOAD_A;
                  end else begin
                     b_flat[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= in_if.in_data;
                     idx <= idx + 1'b1;
                  end
               end
            end
            START: begin
               wd    <= '0;
               state <= WAIT_DONE;
            end
            default: begin
               wd <= wd + 1'b1;
               // done takes priority over a coincident watchdog expiry
               if (mult_done) begin
                  frame_count <= frame_count + 16'd1;
                  state       <= LOAD_A;
               end else if (wd == WD_LAST) begin
                  timeout <= 1'b1;
                  state   <= LOAD_A;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int T  = 1024;
   localparam int NN = N * N;
   localparam int FW = NN * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          mult_done = 1'b0;
   logic [FW-1:0] a_flat, b_flat;
   logic          start_mult, busy, frame_err, timeout;
   logic [15:0]   frame_count;

   matrix_operand_loader_if #(.DATA_WIDTH(DW)) bus ();

   matrix_operand_loader #(
      .MATRIX_SIZE(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst(rst), .in_if(bus),
      .a_flat(a_flat), .b_flat(b_flat), .start_mult(start_mult),
      .mult_done(mult_done), .busy(busy), .frame_err(frame_err),
      .timeout(timeout), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the whole frame, plus a wait phase.
   logic [DW-1:0] m_a [NN];
   logic [DW-1:0] m_b [NN];
   int            m_pos = 0;
   int            m_wait_cycles = 0;
   int            m_count = 0;
   bit            m_start = 0, m_wait = 0, m_ferr = 0, m_tout = 0;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NN; i++) begin m_a[i] = '0; m_b[i] = '0; end
         m_pos = 0; m_count = 0; m_wait_cycles = 0;
         m_start = 0; m_wait = 0; m_ferr = 0; m_tout = 0;
      end else begin
         m_ferr = 0;
         m_tout = 0;
         if (m_start) begin
            m_start = 0; m_wait = 1; m_wait_cycles = 0;
         end else if (m_wait) begin
            m_wait_cycles++;
            if (mult_done) begin
               m_count = (m_count + 1) % 65536; m_wait = 0;
            end else if (m_wait_cycles == T) begin
               m_tout = 1; m_wait = 0;
            end
         end else if (bus.in_valid) begin
            if (bus.in_last && m_pos != 2*NN-1) begin
               m_ferr = 1; m_pos = 0;
            end else begin
               if (m_pos < NN) m_a[m_pos] = bus.in_data;
               else            m_b[m_pos-NN] = bus.in_data;
               if (m_pos == 2*NN-1) begin
                  m_pos = 0;
                  if (bus.in_last) m_start = 1; else m_ferr = 1;
               end else begin
                  m_pos++;
               end
            end
         end
      end
   end

   function automatic logic [FW-1:0] exp_flat(input bit sel_b);
      logic [FW-1:0] r;
      r = '0;
      for (int i = 0; i < NN; i++) r[i*DW +: DW] = sel_b ? m_b[i] : m_a[i];
      return r;
   endfunction

   // {in_ready, start_mult, busy, frame_err, timeout}
   function automatic logic [4:0] exp_ctl();
      return {rst && !(m_start || m_wait), m_start, m_start || m_wait, m_ferr, m_tout};
   endfunction

   logic [4:0] obs_ctl;
   assign obs_ctl = {bus.in_ready, start_mult, busy, frame_err, timeout};

   logic [DW-1:0] fbuf [2*NN];

   task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit done);
      bus.in_valid = v; bus.in_data = d; bus.in_last = l; mult_done = done;
      @(posedge clk); #1;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 2*NN; i++) fbuf[i] = DW'($urandom);
   endtask

   task automatic fill_seq(input int base);
      for (int i = 0; i < 2*NN; i++) fbuf[i] = DW'(base + i);
   endtask

   // Streams fbuf[0..n-1]; returns the number of cycles whose control outputs
   // disagreed with the model.
   task automatic send_frame(input int n, input int last_at, input bit gaps, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            for (int j = 0; j < g; j++) begin
               step(1'b0, DW'($urandom), 1'($urandom), 1'($urandom));
               if (obs_ctl !== exp_ctl()) bad++;
            end
         end
         step(1'b1, fbuf[i], (i == last_at), 1'($urandom));
         if (obs_ctl !== exp_ctl()) bad++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      checks++; if (obs_ctl !== 5'b0) begin errors++; $display("FAIL reset_ctl: got %b want %b", obs_ctl, 5'b0); end
      checks++; if (a_flat !== '0 || b_flat !== '0) begin errors++; $display("FAIL reset_flat: got a=%h b=%h want 0", a_flat, b_flat); end
      checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", frame_count); end
      rst = 1'b1; #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_basic_frame();
      int bad;
      fill_seq(1);
      send_frame(2*NN, 2*NN-1, 1'b0, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_ctl: got %0d bad cycles want 0", bad); end
      checks++; if (start_mult !== 1'b1 || obs_ctl !== exp_ctl()) begin errors++; $display("FAIL basic_start: got %b want %b", obs_ctl, exp_ctl()); end
      checks++; if (a_flat[0 +: DW] !== 8'd1 || a_flat[15*DW +: DW] !== 8'd16) begin errors++; $display("FAIL basic_a_corner: got %0d/%0d want 1/16", a_flat[0 +: DW], a_flat[15*DW +: DW]); end
      checks++; if (b_flat[0 +: DW] !== 8'd17 || b_flat[15*DW +: DW] !== 8'd32) begin errors++; $display("FAIL basic_b_corner: got %0d/%0d want 17/32", b_flat[0 +: DW], b_flat[15*DW +: DW]); end
      checks++; if (a_flat !== exp_flat(0) || b_flat !== exp_flat(1)) begin errors++; $display("FAIL basic_flat: got a=%h b=%h want a=%h b=%h", a_flat, b_flat, exp_flat(0), exp_flat(1)); end
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      checks++; if (start_mult !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_pulse_width: got start=%b busy=%b want 0/1", start_mult, busy); end
   endtask

   task automatic test_wait_done();
      int bad = 0, fbad = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'($urandom), DW'($urandom), 1'($urandom), 1'b0);
         if (obs_ctl !== exp_ctl()) bad++;
         if (a_flat !== exp_flat(0) || b_flat !== exp_flat(1)) fbad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wait_ctl: got %0d bad cycles want 0", bad); end
      checks++; if (fbad !== 0) begin errors++; $display("FAIL wait_operands_frozen: got %0d bad cycles want 0", fbad); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL done_count: got %0d want 1", frame_count); end
      checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_ready: got ready=%b busy=%b want 1/0", bus.in_ready, busy); end
   endtask

   task automatic test_frame_err_early();
      int bad;
      fill_random();
      send_frame(9, -1, 1'b0, bad);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      checks++; if (frame_err !== 1'b1 || obs_ctl !== exp_ctl()) begin errors++; $display("FAIL early_last_err: got %b want %b", obs_ctl, exp_ctl()); end
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_last_pulse: got %b want 0", frame_err); end
      fill_seq(8'hA0);
      send_frame(2*NN, 2*NN-1, 1'b1, bad);
      checks++; if (bad !== 0 || start_mult !== 1'b1) begin errors++; $display("FAIL resync_start: got bad=%0d start=%b want 0/1", bad, start_mult); end
      checks++; if (a_flat[0 +: DW] !== 8'hA0 || b_flat[15*DW +: DW] !== 8'hBF) begin errors++; $display("FAIL resync_corner: got %h/%h want a0/bf", a_flat[0 +: DW], b_flat[15*DW +: DW]); end
      checks++; if (a_flat !== exp_flat(0) || b_flat !== exp_flat(1)) begin errors++; $display("FAIL resync_flat: got a=%h b=%h want a=%h b=%h", a_flat, b_flat, exp_flat(0), exp_flat(1)); end
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL resync_count: got %0d want 2", frame_count); end
   endtask

   task automatic test_missing_last();
      int bad;
      fill_random();
      send_frame(2*NN, -1, 1'b0, bad);
      checks++; if (bad !== 0) begin errors++; $display("FAIL nolast_ctl: got %0d bad cycles want 0", bad); end
      checks++; if (frame_err !== 1'b1 || start_mult !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL nolast_err: got err=%b start=%b ready=%b want 1/0/1", frame_err, start_mult, bus.in_ready); end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         if (obs_ctl !== exp_ctl() || start_mult !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL nolast_no_start: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_timeout();
      int bad, k, cnt0;
      bit seen;
      cnt0 = m_count;
      fill_random();
      send_frame(2*NN, 2*NN-1, 1'b1, bad);
      checks++; if (bad !== 0 || start_mult !== 1'b1) begin errors++; $display("FAIL to_start: got bad=%0d start=%b want 0/1", bad, start_mult); end
      step(1'b0, '0, 1'b0, 1'b0);
      bad = 0; k = 0; seen = 0;
      for (int i = 1; i <= T + 8 && !seen; i++) begin
         step(1'($urandom), DW'($urandom), 1'b0, 1'b0);
         if (obs_ctl !== exp_ctl()) bad++;
         if (timeout === 1'b1) begin seen = 1; k = i; end
      end
      checks++; if (!seen || k !== T) begin errors++; $display("FAIL to_latency: got seen=%0d at %0d want %0d", seen, k, T); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL to_ctl: got %0d bad cycles want 0", bad); end
      checks++; if (frame_count !== 16'(cnt0)) begin errors++; $display("FAIL to_count: got %0d want %0d", frame_count, cnt0); end
      fill_random();
      send_frame(2*NN, 2*NN-1, 1'b0, bad);
      step(1'b0, '0, 1'b0, 1'b0);
      for (int i = 1; i < T; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         if (obs_ctl !== exp_ctl()) bad++;
      end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (timeout !== 1'b0 || frame_count !== 16'(cnt0 + 1) || bus.in_ready !== 1'b1) begin errors++; $display("FAIL to_done_wins: got to=%b cnt=%0d ready=%b want 0/%0d/1", timeout, frame_count, bus.in_ready, cnt0 + 1); end
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (bad !== 0 || timeout !== 1'b0) begin errors++; $display("FAIL to_done_ctl: got bad=%0d to=%b want 0/0", bad, timeout); end
   endtask

   task automatic test_reset_mid();
      int bad, stray;
      fill_random();
      send_frame(20, -1, 1'b0, bad);
      rst = 1'b0;
      step(1'b1, 8'h11, 1'b0, 1'b0);
      checks++; if (obs_ctl !== 5'b0 || a_flat !== '0 || b_flat !== '0 || frame_count !== 16'd0) begin errors++; $display("FAIL rst_mid_load: got ctl=%b cnt=%0d want 0", obs_ctl, frame_count); end
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         if (start_mult !== 1'b0 || obs_ctl !== exp_ctl()) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_load_stray: got %0d bad cycles want 0", stray); end
      fill_random();
      send_frame(2*NN, 2*NN-1, 1'b0, bad);
      for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_wait_pre: got busy=%b want 1", busy); end
      rst = 1'b0;
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (obs_ctl !== 5'b0 || a_flat !== '0 || b_flat !== '0 || frame_count !== 16'd0) begin errors++; $display("FAIL rst_mid_wait: got ctl=%b cnt=%0d want 0", obs_ctl, frame_count); end
      rst = 1'b1;
      stray = 0;
      for (int i = 0; i < T + 10; i++) begin
         step(1'b0, '0, 1'b0, 1'b0);
         if (start_mult !== 1'b0 || timeout !== 1'b0) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL rst_mid_wait_stray: got %0d bad cycles want 0", stray); end
      fill_random();
      send_frame(2*NN, 2*NN-1, 1'b1, bad);
      checks++; if (bad !== 0 || start_mult !== 1'b1 || a_flat !== exp_flat(0) || b_flat !== exp_flat(1)) begin errors++; $display("FAIL rst_recover_frame: got bad=%0d start=%b want 0/1", bad, start_mult); end
      step(1'b0, '0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL rst_recover_count: got %0d want 1", frame_count); end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      test_reset();
      test_basic_frame();
      test_wait_done();
      test_frame_err_early();
      test_missing_last();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
